rng_result_reader: RTL and testbench

- Read-out end of the random-number statistical test counters: snapshots the per-bin 64-bit hit counters and the 64-bit sample total, then streams them as a framed sequence of 32-bit words over a valid/ready interface toward the host link (UART/FIFO bridge).
- Sits between the test-statistic counter block and the host transport.
- Decouples counting from read-out: the counters may keep running while a frame drains.

---
 rtl/rng_result_reader.sv | 146 ++++++++++++++
 tb/tb_rng_result_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_result_reader.sv
// rng_result_reader: snapshots the RNG test bin counters and sample total,
// then streams them to the host link as one framed sequence of 32-bit words:
// header, total hi/lo, each bin hi/lo, then an XOR checksum flagged m_last.
module rng_result_reader #(
   parameter int unsigned       NUM_BINS = 32,
   parameter int unsigned       CNT_W    = 64,
   parameter int unsigned       WORD_W   = 32,
   parameter logic [WORD_W-1:0] HEADER   = 32'hA5A5_0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  counts [NUM_BINS-1:0],
   input  logic [CNT_W-1:0]  total,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned       IDX_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BINS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      HDR,
      TOT_HI,
      TOT_LO,
      BIN_HI,
      BIN_LO,
      CSUM
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    snap_counts [NUM_BINS-1:0];
   logic [CNT_W-1:0]    snap_total;
   logic [IDX_W-1:0]    bin_idx;
   logic [WORD_W-1:0]   csum;
   logic                xfer;

   // a word leaves on this edge
   assign xfer = m_valid && m_ready;

   // frame sequencer: state names the word currently presented on m_data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         snap_counts <= '{default: '0};
         snap_total  <= '0;
         bin_idx     <= '0;
         csum        <= '0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         // every word except the checksum itself folds into the checksum
         if (xfer && state != CSUM) begin
            csum <= csum ^ m_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state <= SNAP;
                  busy  <= 1'b1;
               end
            end

            SNAP: begin
               // coherent capture: every counter from this one edge
               snap_counts <= counts;
               snap_total  <= total;
               bin_idx     <= '0;
               m_data      <= HEADER;
               m_valid     <= 1'b1;
               m_last      <= 1'b0;
               state       <= HDR;
            end

            HDR: begin
               if (xfer) begin
                  m_data <= snap_total[CNT_W-1:WORD_W];
                  state  <= TOT_HI;
               end
            end

            TOT_HI: begin
               if (xfer) begin
                  m_data <= snap_total[WORD_W-1:0];
                  state  <= TOT_LO;
               end
            end

            TOT_LO: begin
               if (xfer) begin
                  m_data <= snap_counts[0][CNT_W-1:WORD_W];
                  state  <= BIN_HI;
               end
            end

            BIN_HI: begin
               if (xfer) begin
                  m_data <= snap_counts[bin_idx][WORD_W-1:0];
                  state  <= BIN_LO;
               end
            end

            BIN_LO: begin
               if (xfer) begin
                  if (bin_idx == LAST_IDX) begin
                     // the word leaving now is the last one the checksum covers
                     m_data <= csum ^ m_data;
                     m_last <= 1'b1;
                     state  <= CSUM;
                  end else begin
                     bin_idx <= bin_idx + IDX_W'(1);
                     m_data  <= snap_counts[bin_idx + IDX_W'(1)][CNT_W-1:WORD_W];
                     state   <= BIN_HI;
                  end
               end
            end

            CSUM: begin
               if (xfer) begin
                  m_valid   <= 1'b0;
                  m_last    <= 1'b0;
                  busy      <= 1'b0;
                  csum      <= '0;
                  frame_cnt <= frame_cnt + 16'd1;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rng_result_reader.sv
// tb_rng_result_reader: scoreboard bench for rng_result_reader; expected
// frames are queued when a capture is requested and checked word by word
// as the DUT hands them off.
module tb_rng_result_reader;

   localparam int unsigned NUM_BINS = 32;
   localparam int unsigned CNT_W    = 64;
   localparam int unsigned WORD_W   = 32;
   localparam logic [31:0] HEADER   = 32'hA5A5_0001;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } word_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  counts [NUM_BINS-1:0];
   logic [CNT_W-1:0]  total;
   logic [WORD_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic              busy;
   logic [15:0]       frame_cnt;

   logic [CNT_W-1:0]  exp_cnt [NUM_BINS-1:0];
   logic [CNT_W-1:0]  exp_tot;
   logic [31:0]       csum_m;

   word_t             sb[$];
   int                n_cmp = 0;
   int                n_err = 0;
   int                n_acc = 0;
   bit                ready_rand = 1'b0;
   bit                hold_pending = 1'b0;
   logic [31:0]       hold_d;
   logic              hold_l;

   rng_result_reader #(
      .NUM_BINS (NUM_BINS),
      .CNT_W    (CNT_W),
      .WORD_W   (WORD_W),
      .HEADER   (HEADER)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .counts    (counts),
      .total     (total),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_w(input logic [31:0] w);
      sb.push_back('{d: w, l: 1'b0});
      csum_m = csum_m ^ w;
   endtask

   // queue the full expected frame built from exp_cnt/exp_tot
   task automatic push_frame();
      csum_m = '0;
      push_w(HEADER);
      push_w(exp_tot[63:32]);
      push_w(exp_tot[31:0]);
      for (int i = 0; i < NUM_BINS; i++) begin
         push_w(exp_cnt[i][63:32]);
         push_w(exp_cnt[i][31:0]);
      end
      sb.push_back('{d: csum_m, l: 1'b1});
   endtask

   task automatic churn_inputs();
      for (int i = 0; i < NUM_BINS; i++) counts[i] = {$urandom, $urandom};
      total = {$urandom, $urandom};
   endtask

   // request a frame and drain it; churn scrambles inputs except on the
   // capture edge, poke fires ignored start pulses mid-frame and at CSUM
   task automatic run_frame(input bit churn, input bit poke);
      int n;
      if (churn) churn_inputs();
      else begin
         counts = exp_cnt;
         total  = exp_tot;
      end
      start = 1'b1;
      @(posedge clk); #2;
      start  = 1'b0;
      counts = exp_cnt;
      total  = exp_tot;
      push_frame();
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("valid_in_snap", 64'(m_valid), 64'd0);
      @(posedge clk); #2;
      n = 0;
      while (busy && n < 3000) begin
         if (churn) churn_inputs();
         if (poke) start = (n == 5) || (n == 40) || (m_valid && m_last);
         @(posedge clk); #2;
         start = 1'b0;
         n++;
      end
      start = 1'b0;
      chk("frame_timeout", 64'(n < 3000), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      repeat (5) begin
         @(posedge clk); #2;
         chk("idle_valid", 64'(m_valid), 64'd0);
      end
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   // ready driver and output monitor, acting on the falling edge
   initial begin
      word_t e;
      m_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               chk("hold_valid", 64'(m_valid), 64'd1);
               chk("hold_data", 64'(m_data), 64'(hold_d));
               chk("hold_last", 64'(m_last), 64'(hold_l));
            end
            m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
               chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("word", 64'(m_data), 64'(e.d));
                  chk("last", 64'(m_last), 64'(e.l));
               end
               n_acc++;
               hold_pending = 1'b0;
            end else if (m_valid) begin
               hold_pending = 1'b1;
               hold_d       = m_data;
               hold_l       = m_last;
            end else begin
               hold_pending = 1'b0;
            end
         end
      end
   end

   initial begin
      int base;
      int n;
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < NUM_BINS; i++) counts[i] = '0;
      total = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_last", 64'(m_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      // all-zero bins, total 4
      for (int i = 0; i < NUM_BINS; i++) exp_cnt[i] = '0;
      exp_tot = 64'd4;
      run_frame(1'b0, 1'b0);
      chk("frame_cnt_1", 64'(frame_cnt), 64'd1);

      // indexed pattern
      for (int i = 0; i < NUM_BINS; i++) exp_cnt[i] = {32'(i), 32'h100 + 32'(i)};
      exp_tot = 64'h1_0000_0080;
      run_frame(1'b0, 1'b0);
      chk("frame_cnt_2", 64'(frame_cnt), 64'd2);

      // same pattern under random backpressure
      ready_rand = 1'b1;
      run_frame(1'b0, 1'b0);
      chk("frame_cnt_3", 64'(frame_cnt), 64'd3);

      // inputs changing every cycle around the capture
      for (int i = 0; i < NUM_BINS; i++) exp_cnt[i] = {$urandom, $urandom};
      exp_tot = {$urandom, $urandom};
      run_frame(1'b1, 1'b0);
      chk("frame_cnt_4", 64'(frame_cnt), 64'd4);
      ready_rand = 1'b0;

      // start pulses while busy and on the CSUM acceptance edge
      run_frame(1'b0, 1'b1);
      chk("frame_cnt_5", 64'(frame_cnt), 64'd5);

      // reset after word 20 is accepted
      base   = n_acc;
      counts = exp_cnt;
      total  = exp_tot;
      start  = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      push_frame();
      n = 0;
      while (n_acc < base + 20 && n < 500) begin
         @(posedge clk); #2;
         n++;
      end
      chk("mid_reset_reach", 64'(n_acc - base), 64'd20);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(m_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      sb.delete();
      hold_pending = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;
      for (int i = 0; i < NUM_BINS; i++) exp_cnt[i] = {32'(i) ^ 32'hDEAD_0000, 32'(i) * 32'd7};
      exp_tot = 64'hFFFF_FFFF_0000_0001;
      run_frame(1'b0, 1'b0);
      chk("frame_cnt_after_rst", 64'(frame_cnt), 64'd1);

      // frame counter wrap
      force dut.frame_cnt = 16'hFFFF;
      @(posedge clk); #2;
      release dut.frame_cnt;
      @(posedge clk); #2;
      chk("frame_cnt_forced", 64'(frame_cnt), 64'hFFFF);
      run_frame(1'b0, 1'b0);
      chk("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
